// File: rtl/mem_loop_ctrl_if.sv
// rtl/mem_loop_ctrl_if.sv - bus bundle between a loop-nest controller and its driver
//
// Carries the configuration/control inputs and the step/status outputs of
// mem_loop_ctrl. The master modport is the side that configures and starts
// the walk. The slave modport is the controller itself.
//   cfg_loop_iter_v / cfg_loop_iter : write one loop iteration count (count-1)
//   block_done                      : clear the loop configuration
//   start / stall                   : begin a walk / freeze stepping this cycle
//   start_out                       : one-cycle launch pulse
//   iter_done                       : [NUM_MAX_LOOPS] step strobe, [i] loop i wraps
//   busy / done                     : walk in progress / walk finished pulse
//   stall_cycles                    : stalled RUN cycle count (optional counter)
interface mem_loop_ctrl_if #(
    parameter int LOOP_ITER_W   = 16,
    parameter int NUM_MAX_LOOPS = 32
);
    logic                     cfg_loop_iter_v;
    logic [LOOP_ITER_W-1:0]   cfg_loop_iter;
    logic                     block_done;
    logic                     start;
    logic                     stall;
    logic                     start_out;
    logic [NUM_MAX_LOOPS:0]   iter_done;
    logic                     busy;
    logic                     done;
    logic [31:0]              stall_cycles;

    modport master (
        output cfg_loop_iter_v, cfg_loop_iter, block_done, start, stall,
        input  start_out, iter_done, busy, done, stall_cycles
    );

    modport slave (
        input  cfg_loop_iter_v, cfg_loop_iter, block_done, start, stall,
        output start_out, iter_done, busy, done, stall_cycles
    );
endinterface

// File: rtl/mem_loop_ctrl.sv
// rtl/mem_loop_ctrl.sv - nested loop step controller for memory address walkers
//
// Holds up to NUM_MAX_LOOPS iteration counts (slot 0 outermost), and on start
// walks the whole nest, issuing one step strobe per non-stalled RUN cycle
// together with per-loop wrap flags.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : mem_loop_ctrl_if.slave (config, start/stall, step/status outputs)
// Optional feature: define MEM_LOOP_CTRL_STALL_CNT_EN to build the saturating
// stall_cycles counter; otherwise stall_cycles is constant 0.
module mem_loop_ctrl #(
    parameter int LOOP_ID_W     = 5,
    parameter int LOOP_ITER_W   = 16,
    parameter int NUM_MAX_LOOPS = 1 << LOOP_ID_W
) (
    input  logic          clk,
    input  logic          reset,
    mem_loop_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_RUN    = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    localparam logic [LOOP_ID_W:0]   PTR_FULL = (LOOP_ID_W + 1)'(NUM_MAX_LOOPS);
    localparam logic [LOOP_ID_W:0]   PTR_ONE  = (LOOP_ID_W + 1)'(1);
    localparam logic [LOOP_ITER_W-1:0] CNT_ONE = LOOP_ITER_W'(1);

    state_t                  state;
    state_t                  state_nxt;
    logic [LOOP_ID_W:0]      ptr;
    logic [LOOP_ITER_W-1:0]  iter_max [NUM_MAX_LOOPS];
    logic [LOOP_ITER_W-1:0]  cnt      [NUM_MAX_LOOPS];
    logic [NUM_MAX_LOOPS-1:0] at_max;
    // wrap_chain[i]: every loop j >= i sits at its last iteration.
    // The top bit is a constant 1, so the chain doubles as the iter_done word.
    logic [NUM_MAX_LOOPS:0]  wrap_chain;
    logic                    start_acc;
    logic                    step;

    assign start_acc = (state == S_IDLE) && bus.start;
    assign step      = (state == S_RUN) && !bus.stall;

    // Configuration is only writable while idle; block_done beats a write.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
            for (int i = 0; i < NUM_MAX_LOOPS; i++) iter_max[i] <= '0;
        end else if (state == S_IDLE) begin
            if (bus.block_done) begin
                ptr <= '0;
                for (int i = 0; i < NUM_MAX_LOOPS; i++) iter_max[i] <= '0;
            end else if (bus.cfg_loop_iter_v && (ptr < PTR_FULL)) begin
                iter_max[ptr[LOOP_ID_W-1:0]] <= bus.cfg_loop_iter;
                ptr <= ptr + PTR_ONE;
            end
        end
    end

    // One equality compare per loop, then an AND chain from the innermost loop.
    always_comb begin
        at_max     = '0;
        wrap_chain = '0;
        for (int i = 0; i < NUM_MAX_LOOPS; i++) at_max[i] = (cnt[i] == iter_max[i]);
        wrap_chain[NUM_MAX_LOOPS] = 1'b1;
        for (int i = NUM_MAX_LOOPS - 1; i >= 0; i--) wrap_chain[i] = wrap_chain[i+1] & at_max[i];
    end

    // A loop advances when everything inside it wraps but it does not; loops
    // that wrap go back to 0. This carries like an odometer with per-digit limits.
    always_ff @(posedge clk) begin
        if (reset || start_acc) begin
            for (int i = 0; i < NUM_MAX_LOOPS; i++) cnt[i] <= '0;
        end else if (step) begin
            for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
                if (wrap_chain[i]) cnt[i] <= '0;
                else if (wrap_chain[i+1]) cnt[i] <= cnt[i] + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bus.start) state_nxt = S_LAUNCH;
            S_LAUNCH: state_nxt = S_RUN;
            S_RUN:    if (step && wrap_chain[0]) state_nxt = S_FIN;
            S_FIN:    state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, even before the first edge.
    always_comb begin
        bus.start_out = 1'b0;
        bus.iter_done = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        if (!reset) begin
            bus.start_out = (state == S_LAUNCH);
            bus.busy      = (state != S_IDLE);
            bus.done      = (state == S_FIN);
            if (step) bus.iter_done = wrap_chain;
        end
    end

`ifdef MEM_LOOP_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (reset || start_acc) stall_cnt <= '0;
        else if ((state == S_RUN) && bus.stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stall_cycles = reset ? '0 : stall_cnt;
`else
    assign bus.stall_cycles = '0;
`endif
endmodule

// File: tb/tb_mem_loop_ctrl.sv
// tb/tb_mem_loop_ctrl.sv - table-driven checks for mem_loop_ctrl
module tb_mem_loop_ctrl;
    localparam int IW = 8;
    localparam int NL = 4;

`ifdef MEM_LOOP_CTRL_STALL_CNT_EN
    localparam logic [31:0] S1 = 32'd1;
    localparam logic [31:0] S2 = 32'd2;
    localparam logic [31:0] S3 = 32'd3;
`else
    localparam logic [31:0] S1 = 32'd0;
    localparam logic [31:0] S2 = 32'd0;
    localparam logic [31:0] S3 = 32'd0;
`endif

    typedef struct {
        logic          rst;
        logic          cv;
        logic [IW-1:0] cd;
        logic          bd;
        logic          st;
        logic          sl;
        logic          e_so;
        logic [NL:0]   e_id;
        logic          e_busy;
        logic          e_done;
        logic [31:0]   e_sc;
    } vec_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    mem_loop_ctrl_if #(.LOOP_ITER_W(IW), .NUM_MAX_LOOPS(NL)) bus ();

    mem_loop_ctrl #(
        .LOOP_ID_W(2),
        .LOOP_ITER_W(IW),
        .NUM_MAX_LOOPS(NL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t v(input logic rst, input logic cv, input logic [IW-1:0] cd,
                               input logic bd, input logic st, input logic sl,
                               input logic so, input logic [NL:0] id, input logic bz,
                               input logic dn, input logic [31:0] sc);
        vec_t r;
        r.rst = rst; r.cv = cv; r.cd = cd; r.bd = bd; r.st = st; r.sl = sl;
        r.e_so = so; r.e_id = id; r.e_busy = bz; r.e_done = dn; r.e_sc = sc;
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int steps;
    int wraps0;
    int done_seen;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        bus.cfg_loop_iter_v = 1'b0;
        bus.cfg_loop_iter   = '0;
        bus.block_done      = 1'b0;
        bus.start           = 1'b0;
        bus.stall           = 1'b0;

        //              rst cv cd bd st sl   so id        bz dn sc
        // reset, then an unconfigured walk: one step with every flag set
        vecs.push_back(v(1, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        // two-loop walk: slot0=1, slot1=2 -> 6 steps
        vecs.push_back(v(0, 1, 1, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 1, 2, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11110, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        // same walk with three stalled cycles before step 2
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 5'b00000, 1, 0, S1));
        vecs.push_back(v(0, 0, 0, 0, 0, 1,   0, 5'b00000, 1, 0, S2));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11110, 1, 0, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11111, 1, 0, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 1, 1, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, S3));
        // start during RUN ignored, then reset at step 4 aborts without done
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, S3));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b11100, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11110, 1, 0, 0));
        vecs.push_back(v(1, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        // five writes {1,0,0,1,2}: fifth dropped -> 2*1*1*2 = 4 steps
        vecs.push_back(v(0, 1, 1, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 1, 1, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 1, 2, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b10000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 1, 0, 0,   0, 5'b11110, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b10000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));
        // block_done during RUN kept the configuration: same 4 steps again
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b10000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11110, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b10000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 1, 1, 0));
        // block_done in IDLE, then block_done wins over a coincident write
        vecs.push_back(v(0, 0, 0, 1, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 1, 3, 1, 0, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 1, 0,   0, 5'b00000, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   1, 5'b00000, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b11111, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 1, 1, 0));
        vecs.push_back(v(0, 0, 0, 0, 0, 0,   0, 5'b00000, 0, 0, 0));

        for (int k = 0; k < vecs.size(); k++) begin
            reset               = vecs[k].rst;
            bus.cfg_loop_iter_v = vecs[k].cv;
            bus.cfg_loop_iter   = vecs[k].cd;
            bus.block_done      = vecs[k].bd;
            bus.start           = vecs[k].st;
            bus.stall           = vecs[k].sl;
            @(negedge clk);
            check("start_out",    k, 32'(bus.start_out), 32'(vecs[k].e_so));
            check("iter_done",    k, 32'(bus.iter_done), 32'(vecs[k].e_id));
            check("busy",         k, 32'(bus.busy),      32'(vecs[k].e_busy));
            check("done",         k, 32'(bus.done),      32'(vecs[k].e_done));
            check("stall_cycles", k, bus.stall_cycles,   vecs[k].e_sc);
            tick();
        end
        reset               = 1'b0;
        bus.cfg_loop_iter_v = 1'b0;
        bus.block_done      = 1'b0;
        bus.start           = 1'b0;
        bus.stall           = 1'b0;

        // Full-width count: iter_max all ones gives 2^IW steps, one outer wrap.
        bus.cfg_loop_iter_v = 1'b1;
        bus.cfg_loop_iter   = {IW{1'b1}};
        tick();
        bus.cfg_loop_iter_v = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        steps = 0;
        wraps0 = 0;
        done_seen = 0;
        for (int c = 0; c < 2000 && done_seen == 0; c++) begin
            @(negedge clk);
            if (bus.iter_done[NL]) steps++;
            if (bus.iter_done[0]) wraps0++;
            if (bus.done) done_seen = 1;
            tick();
        end
        check("ones_steps", 1000, steps, 256);
        check("ones_wrap0", 1000, wraps0, 1);
        check("ones_done",  1000, done_seen, 1);

        // Stall on what would be the final step: counters hold, no early finish.
        bus.block_done = 1'b1;
        tick();
        bus.block_done = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.stall = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("fstall_id",   2000 + c, 32'(bus.iter_done), 32'd0);
            check("fstall_busy", 2000 + c, 32'(bus.busy), 32'd1);
            tick();
        end
        bus.stall = 1'b0;
        @(negedge clk);
        check("fstall_step", 2002, 32'(bus.iter_done), 32'h1f);
        check("fstall_sc",   2002, bus.stall_cycles, S2);
        tick();
        @(negedge clk);
        check("fstall_done", 2003, 32'(bus.done), 32'd1);
        tick();
        @(negedge clk);
        check("fstall_idle", 2004, 32'(bus.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
